// File: rtl/cacheline_burst_adapter.sv
// cacheline_burst_adapter: splits 256-bit line reads/writes into 4-beat 64-bit pmem bursts
module cacheline_burst_adapter #(
  parameter int LINE_W = 256,
  parameter int BURST_W = 64,
  parameter int ADDR_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               line_read,
  input  logic               line_write,
  input  logic [ADDR_W-1:0]  line_addr,
  input  logic [LINE_W-1:0]  line_wdata,
  output logic [LINE_W-1:0]  line_rdata,
  output logic               line_resp,
  output logic               pmem_read,
  output logic               pmem_write,
  output logic [ADDR_W-1:0]  pmem_addr,
  output logic [BURST_W-1:0] pmem_wdata,
  input  logic [BURST_W-1:0] pmem_rdata,
  input  logic               pmem_resp
);
  localparam int BEATS = LINE_W / BURST_W;
  localparam int OFF = $clog2(LINE_W / 8);
  localparam int CW = $clog2(BEATS);
  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [ADDR_W-1:0] addr_q;
  logic [LINE_W-1:0] wline_q;
  logic busy, last, start;
  assign busy = state == RD || state == WR;
  assign last = busy && pmem_resp && cnt == CW'(BEATS - 1);
  assign start = state == IDLE && (line_read || line_write);
  assign pmem_addr = addr_q;
  always_ff @(posedge clk)
    if (!rst) state <= IDLE;
    else state <= state_n;
  // write wins over read so a dirty victim leaves before its replacement arrives
  always_comb
    state_n = state == IDLE ? (line_write ? WR : line_read ? RD : IDLE)
            : state == DONE ? IDLE
            : last ? DONE : state;
  always_ff @(posedge clk)
    if (!rst) begin
      cnt <= '0;
      addr_q <= '0;
      wline_q <= '0;
      line_rdata <= '0;
    end else begin
      if (start) addr_q <= line_addr & ~ADDR_W'((1 << OFF) - 1);
      if (state == IDLE && line_write) wline_q <= line_wdata;
      if (busy && pmem_resp) cnt <= cnt + CW'(1);
      if (state == RD && pmem_resp) line_rdata[cnt*BURST_W +: BURST_W] <= pmem_rdata;
    end
  always_comb begin
    pmem_read = state == RD;
    pmem_write = state == WR;
    line_resp = state == DONE;
    pmem_wdata = state == WR ? wline_q[cnt*BURST_W +: BURST_W] : '0;
  end
endmodule
